sigmoid_arbiter: RTL and testbench

SIGMOID_ARBITER -- requirements
Module: sigmoid_arbiter

---
 rtl/sigmoid_arbiter_if.sv | 26 ++
 rtl/sigmoid_arbiter.sv | 85 ++++++++
 tb/tb_sigmoid_arbiter.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sigmoid_arbiter_if.sv
// rtl/sigmoid_arbiter_if.sv - request, sigmoid datapath and response signals of sigmoid_arbiter
interface sigmoid_arbiter_if;
   logic        req0_valid;
   logic [15:0] req0_x;
   logic        req0_ready;
   logic        req1_valid;
   logic [15:0] req1_x;
   logic        req1_ready;
   logic [15:0] sig_x;
   logic [15:0] sig_y;
   logic        rsp_valid;
   logic [15:0] rsp_y;
   logic        rsp_id;
   logic        rsp_ready;
   logic        busy;

   modport slave (
      input  req0_valid, req0_x, req1_valid, req1_x, sig_y, rsp_ready,
      output req0_ready, req1_ready, sig_x, rsp_valid, rsp_y, rsp_id, busy
   );

   modport master (
      output req0_valid, req0_x, req1_valid, req1_x, sig_y, rsp_ready,
      input  req0_ready, req1_ready, sig_x, rsp_valid, rsp_y, rsp_id, busy
   );
endinterface

// File: rtl/sigmoid_arbiter.sv
// rtl/sigmoid_arbiter.sv - two-requester round-robin front end for a shared combinational sigmoid
module sigmoid_arbiter #(
   parameter int unsigned SETTLE_CYCLES = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   sigmoid_arbiter_if.slave bus
);
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EVAL = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   localparam logic [3:0] LP_CNT_LAST = 4'(SETTLE_CYCLES - 1);

   state_t      r_state;
   state_t      w_state_nxt;
   logic [15:0] r_x;
   logic [15:0] r_y;
   logic        r_id;
   logic        r_last_id;
   logic [3:0]  r_cnt;
   logic        w_idle;
   logic        w_gnt1;
   logic        w_rdy0;
   logic        w_rdy1;
   logic        w_accept;
   logic        w_settled;

   // Readys are gated by rst_n so nothing is offered while reset is held.
   assign w_idle    = rst_n && (r_state == ST_IDLE);
   assign w_gnt1    = bus.req1_valid && (!bus.req0_valid || !r_last_id);
   assign w_rdy0    = w_idle && bus.req0_valid && !w_gnt1;
   assign w_rdy1    = w_idle && w_gnt1;
   assign w_accept  = w_rdy0 || w_rdy1;
   assign w_settled = (r_state == ST_EVAL) && (r_cnt == LP_CNT_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (w_accept)      w_state_nxt = ST_EVAL;
         ST_EVAL: if (w_settled)     w_state_nxt = ST_RESP;
         ST_RESP: if (bus.rsp_ready) w_state_nxt = ST_IDLE;
         default:                    w_state_nxt = ST_IDLE;
      endcase
   end

   // x_reg only changes on an accept so the datapath input is stable while settling.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_x       <= 16'h0000;
         r_y       <= 16'h0000;
         r_id      <= 1'b0;
         r_last_id <= 1'b1;
         r_cnt     <= 4'd0;
      end else if (w_accept) begin
         r_x       <= w_rdy1 ? bus.req1_x : bus.req0_x;
         r_id      <= w_rdy1;
         r_last_id <= w_rdy1;
         r_cnt     <= 4'd0;
      end else if (r_state == ST_EVAL) begin
         r_cnt <= r_cnt + 4'd1;
         if (w_settled) begin
            r_y <= bus.sig_y;
         end
      end
   end

   assign bus.req0_ready = w_rdy0;
   assign bus.req1_ready = w_rdy1;
   assign bus.sig_x      = r_x;
   assign bus.rsp_valid  = (r_state == ST_RESP);
   assign bus.rsp_y      = r_y;
   assign bus.rsp_id     = r_id;
   assign bus.busy       = (r_state != ST_IDLE);
endmodule

// File: tb/tb_sigmoid_arbiter.sv
// tb/tb_sigmoid_arbiter.sv - directed and randomized checks of sigmoid_arbiter against a transaction model
module tb_sigmoid_arbiter;
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   sigmoid_arbiter_if ifa ();
   sigmoid_arbiter_if ifb ();

   sigmoid_arbiter #(.SETTLE_CYCLES(1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
   sigmoid_arbiter #(.SETTLE_CYCLES(4)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

   logic        v0 [2];
   logic        v1 [2];
   logic [15:0] x0 [2];
   logic [15:0] x1 [2];
   logic        rr [2];
   logic        r0_o [2];
   logic        r1_o [2];
   logic        rv_o [2];
   logic        id_o [2];
   logic        bz_o [2];
   logic [15:0] sx_o [2];
   logic [15:0] ry_o [2];

   // Piecewise-linear sigmoid in Q8.8 standing in for the shared datapath.
   function automatic logic [15:0] plan(input logic [15:0] x);
      int a;
      int y;
      a = int'($signed(x));
      if (a < 0) a = -a;
      if (a >= 1280)     y = 256;
      else if (a >= 608) y = a / 32 + 216;
      else if (a >= 256) y = a / 8 + 160;
      else               y = a / 4 + 128;
      if ($signed(x) < 0) y = 256 - y;
      return 16'(y);
   endfunction

   assign ifa.req0_valid = v0[0];
   assign ifa.req0_x     = x0[0];
   assign ifa.req1_valid = v1[0];
   assign ifa.req1_x     = x1[0];
   assign ifa.rsp_ready  = rr[0];
   assign ifa.sig_y      = plan(ifa.sig_x);
   assign ifb.req0_valid = v0[1];
   assign ifb.req0_x     = x0[1];
   assign ifb.req1_valid = v1[1];
   assign ifb.req1_x     = x1[1];
   assign ifb.rsp_ready  = rr[1];
   assign ifb.sig_y      = plan(ifb.sig_x);

   assign r0_o[0] = ifa.req0_ready;
   assign r1_o[0] = ifa.req1_ready;
   assign rv_o[0] = ifa.rsp_valid;
   assign id_o[0] = ifa.rsp_id;
   assign bz_o[0] = ifa.busy;
   assign sx_o[0] = ifa.sig_x;
   assign ry_o[0] = ifa.rsp_y;
   assign r0_o[1] = ifb.req0_ready;
   assign r1_o[1] = ifb.req1_ready;
   assign rv_o[1] = ifb.rsp_valid;
   assign id_o[1] = ifb.rsp_id;
   assign bz_o[1] = ifb.busy;
   assign sx_o[1] = ifb.sig_x;
   assign ry_o[1] = ifb.rsp_y;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // Transaction model: an in-flight flag plus edges elapsed since its accept.
   bit          m_busy [2];
   int          m_age  [2];
   logic [15:0] m_x    [2];
   logic [15:0] m_y    [2];
   logic        m_id   [2];
   logic        m_last [2];
   bit          acc0   [2];
   bit          acc1   [2];
   int          gq [$];
   int          gcyc [$];
   int          hs_id [$];
   int          hs_y [$];
   int          hs_cyc [$];

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] want);
      total++;
      if (obs !== want) begin
         bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, want, cyc);
      end
   endtask

   function automatic int settle(input int d);
      return (d == 0) ? 1 : 4;
   endfunction

   function automatic logic [15:0] rand_x();
      logic [15:0] x;
      x = 16'($urandom_range(0, 1536));
      if ($urandom_range(0, 1) == 1) x = -x;
      if ($urandom_range(0, 7) == 0) x = 16'($urandom);
      return x;
   endfunction

   task automatic model_reset(input int d);
      m_busy[d] = 1'b0;
      m_age[d]  = 0;
      m_x[d]    = 16'h0000;
      m_y[d]    = 16'h0000;
      m_id[d]   = 1'b0;
      m_last[d] = 1'b1;
   endtask

   function automatic int exp_grant(input int d);
      if (!rst_n || m_busy[d]) return -1;
      if (v0[d] && v1[d]) return m_last[d] ? 0 : 1;
      if (v0[d]) return 0;
      if (v1[d]) return 1;
      return -1;
   endfunction

   task automatic tick();
      int g;
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         if (!rst_n) model_reset(d);
         g = exp_grant(d);
         check_eq($sformatf("d%0d.req0_ready", d), r0_o[d], g == 0);
         check_eq($sformatf("d%0d.req1_ready", d), r1_o[d], g == 1);
         check_eq($sformatf("d%0d.one_ready", d), r0_o[d] & r1_o[d], 0);
         check_eq($sformatf("d%0d.busy", d), bz_o[d], m_busy[d]);
         check_eq($sformatf("d%0d.rsp_valid", d), rv_o[d], m_busy[d] && m_age[d] >= settle(d));
         check_eq($sformatf("d%0d.sig_x", d), sx_o[d], m_x[d]);
         check_eq($sformatf("d%0d.rsp_y", d), ry_o[d], m_y[d]);
         check_eq($sformatf("d%0d.rsp_id", d), id_o[d], m_id[d]);
      end
      if (r0_o[0]) begin gq.push_back(0); gcyc.push_back(cyc); end
      if (r1_o[0]) begin gq.push_back(1); gcyc.push_back(cyc); end
      if (rv_o[0] && rr[0]) begin
         hs_id.push_back(int'(id_o[0]));
         hs_y.push_back(int'(ry_o[0]));
         hs_cyc.push_back(cyc);
      end
      @(posedge clk);
      for (int d = 0; d < 2; d++) begin
         acc0[d] = 1'b0;
         acc1[d] = 1'b0;
         g = exp_grant(d);
         if (!rst_n) begin
            model_reset(d);
         end else if (g >= 0) begin
            m_busy[d] = 1'b1;
            m_age[d]  = 0;
            m_x[d]    = (g == 1) ? x1[d] : x0[d];
            m_id[d]   = (g == 1);
            m_last[d] = (g == 1);
            acc0[d]   = (g == 0);
            acc1[d]   = (g == 1);
         end else if (m_busy[d]) begin
            if (m_age[d] < settle(d)) begin
               m_age[d]++;
               if (m_age[d] == settle(d)) m_y[d] = plan(m_x[d]);
            end else if (rr[d]) begin
               m_busy[d] = 1'b0;
            end
         end
      end
      cyc++;
      #1;
   endtask

   task automatic refill(input int d, input logic keep);
      if (acc0[d]) begin v0[d] = keep; x0[d] = rand_x(); end
      if (acc1[d]) begin v1[d] = keep; x1[d] = rand_x(); end
   endtask

   initial begin
      int n;
      int base;
      int rel_cyc;
      int seen;
      logic [15:0] y0;
      logic        id0;
      for (int d = 0; d < 2; d++) begin
         v0[d] = 1'b1; v1[d] = 1'b1;
         x0[d] = 16'h0000; x1[d] = 16'h0100;
         rr[d] = 1'b1;
         acc0[d] = 1'b0; acc1[d] = 1'b0;
         model_reset(d);
      end
      tick();
      tick();
      rst_n   = 1'b1;
      rel_cyc = cyc;

      // Tie straight out of reset: requester 0 first, then 1 after one idle cycle.
      n = 0;
      while (hs_id.size() < 2 && n < 30) begin
         tick(); refill(0, 1'b0); refill(1, 1'b0); n++;
      end
      check_eq("tie.responses", hs_id.size(), 2);
      if (hs_id.size() >= 2 && gq.size() >= 2) begin
         check_eq("tie.first_grant_cycle", gcyc[0], rel_cyc);
         check_eq("tie.id0", hs_id[0], 0);
         check_eq("tie.y0", hs_y[0], 32'h0080);
         check_eq("tie.id1", hs_id[1], 1);
         check_eq("tie.y1", hs_y[1], 32'h00C0);
         check_eq("tie.spacing", hs_cyc[1] - hs_cyc[0], 3);
      end

      // Single request, latency from accept to rsp_valid.
      v0[0] = 1'b1; x0[0] = 16'h0000;
      tick(); refill(0, 1'b0); refill(1, 1'b0);
      n = 1;
      while (!rv_o[0] && n < 10) begin tick(); refill(1, 1'b0); n++; end
      check_eq("single.latency", n, 2);
      check_eq("single.rsp_y", ry_o[0], 32'h0080);
      check_eq("single.rsp_id", id_o[0], 0);
      tick();

      // Continuous contention after reset alternates grants.
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      base = gq.size();
      v0[0] = 1'b1; v1[0] = 1'b1; x0[0] = rand_x(); x1[0] = rand_x();
      n = 0;
      while (gq.size() < base + 6 && n < 60) begin tick(); refill(0, 1'b1); n++; end
      check_eq("alt.grants", gq.size() - base, 6);
      for (int i = 0; i < 6 && base + i < gq.size(); i++)
         check_eq($sformatf("alt.grant%0d", i), gq[base + i], i % 2);

      // Backpressure with both requesters still pending.
      rr[0] = 1'b0;
      n = 0;
      while (!rv_o[0] && n < 20) begin tick(); refill(0, 1'b1); n++; end
      check_eq("stall.reached_resp", rv_o[0], 1);
      y0  = ry_o[0];
      id0 = id_o[0];
      for (int k = 0; k < 10; k++) begin
         tick();
         check_eq("stall.rsp_valid", rv_o[0], 1);
         check_eq("stall.rsp_y", ry_o[0], y0);
         check_eq("stall.rsp_id", id_o[0], id0);
         check_eq("stall.readys", r0_o[0] | r1_o[0], 0);
      end
      rr[0] = 1'b1;
      tick();
      v0[0] = 1'b0; v1[0] = 1'b0;

      // Random traffic on both instances with occasional asynchronous resets.
      for (int k = 0; k < 800; k++) begin
         for (int d = 0; d < 2; d++) begin
            if (acc0[d] || !v0[d]) begin v0[d] = ($urandom_range(0, 1) == 1); x0[d] = rand_x(); end
            else if ($urandom_range(0, 7) == 0) v0[d] = 1'b0;
            if (acc1[d] || !v1[d]) begin v1[d] = ($urandom_range(0, 1) == 1); x1[d] = rand_x(); end
            else if ($urandom_range(0, 7) == 0) v1[d] = 1'b0;
            rr[d] = ($urandom_range(0, 3) != 0);
         end
         rst_n = ($urandom_range(0, 199) != 0);
         tick();
      end

      // Reset during the second settling cycle of the SETTLE_CYCLES=4 instance.
      for (int d = 0; d < 2; d++) begin v0[d] = 1'b0; v1[d] = 1'b0; rr[d] = 1'b1; end
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      v0[1] = 1'b1; x0[1] = rand_x();
      tick();
      v0[1] = 1'b0;
      check_eq("abort.accepted", acc0[1], 1);
      tick();
      check_eq("abort.busy_before", bz_o[1], 1);
      rst_n = 1'b0;
      #1;
      check_eq("abort.busy", bz_o[1], 0);
      check_eq("abort.rsp_valid", rv_o[1], 0);
      check_eq("abort.sig_x", sx_o[1], 0);
      check_eq("abort.rsp_y", ry_o[1], 0);
      check_eq("abort.rsp_id", id_o[1], 0);
      tick();
      rst_n = 1'b1;
      seen = 0;
      for (int k = 0; k < 12; k++) begin
         tick();
         if (rv_o[1]) seen++;
      end
      check_eq("abort.no_response", seen, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
